// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and masked round-robin scan.
// Each channel has its own lane slice; the top ORs the lane outputs into a single result.

module mux_scan_n_lane #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 3,
  parameter int K     = 0
) (
  input  logic [SEL_W-1:0] idx,
  input  logic [WIDTH-1:0] din,
  input  logic             msk,
  output logic [WIDTH-1:0] dout,
  output logic             mhit
);
  logic hit;

  assign hit  = (idx == SEL_W'(K));
  assign dout = hit ? din : '0;
  assign mhit = hit & msk;
endmodule

module mux_scan_n #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       mask,
  input  logic [CHANNELS*WIDTH-1:0] I,
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MANUAL = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]       state, nxt;
  logic [SEL_W-1:0] p;
  logic [DW-1:0]    d;

  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] first_ch, next_ch;
  logic             above;
  logic             mask_p;
  logic             sel_ok;
  logic [WIDTH-1:0] data;

  logic [CHANNELS-1:0][WIDTH-1:0] lane_d;
  logic [CHANNELS-1:0]            lane_m;

  assign nxt    = !en ? S_IDLE : (mode ? S_SCAN : S_MANUAL);
  assign idx    = (nxt == S_SCAN) ? p : sel;
  assign sel_ok = (int'(sel) < CHANNELS);

  // An index with no matching lane (out-of-range select) yields zero data.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    mux_scan_n_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .K(k)) u_lane (
      .idx  (idx),
      .din  (I[k*WIDTH +: WIDTH]),
      .msk  (mask[k]),
      .dout (lane_d[k]),
      .mhit (lane_m[k])
    );
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < CHANNELS; k++) data = data | lane_d[k];
    mask_p = |lane_m;
  end

  // Downward walk leaves the lowest set bit, and the lowest set bit above p.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    above    = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_ch = SEL_W'(i);
        if (i > int'(p)) begin
          next_ch = SEL_W'(i);
          above   = 1'b1;
        end
      end
    end
    if (!above) next_ch = first_ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      Out   <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      p     <= '0;
      d     <= '0;
    end else begin
      state <= nxt;
      case (nxt)
        S_MANUAL: begin
          Out   <= sel_ok ? data : '0;
          ch    <= sel;
          valid <= sel_ok;
          wrap  <= 1'b0;
        end
        S_SCAN: begin
          if (state != S_SCAN) begin
            p     <= first_ch;
            d     <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
          end else if (mask == '0) begin
            valid <= 1'b0;
            wrap  <= 1'b0;
          end else if (mask_p) begin
            Out   <= data;
            ch    <= p;
            valid <= 1'b1;
            if (d == D_LAST) begin
              d    <= '0;
              p    <= next_ch;
              wrap <= !above;
            end else begin
              d    <= d + 1'b1;
              wrap <= 1'b0;
            end
          end else begin
            // current channel dropped out of the mask mid-dwell
            p     <= next_ch;
            d     <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
          end
        end
        default: begin
          valid <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: three configurations driven with directed vectors,
// expected samples queued per instance and popped by a monitor after each rising edge.

module tb_mux_scan_n;
  typedef struct {
    logic [3:0] o;
    logic [2:0] c;
    logic       v;
    logic       w;
    int         id;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;
  exp_t q0[$], q1[$], q2[$];

  // u0: WIDTH=4, CHANNELS=8, DWELL=3
  logic        rst0, en0, mode0;
  logic [2:0]  sel0;
  logic [7:0]  mask0;
  logic [31:0] I0;
  logic [3:0]  out0;
  logic [2:0]  ch0;
  logic        v0, w0;

  // u1: WIDTH=4, CHANNELS=8, DWELL=2
  logic        rst1, en1, mode1;
  logic [2:0]  sel1;
  logic [7:0]  mask1;
  logic [31:0] I1;
  logic [3:0]  out1;
  logic [2:0]  ch1;
  logic        v1, w1;

  // u2: WIDTH=4, CHANNELS=6, DWELL=1
  logic        rst2, en2, mode2;
  logic [2:0]  sel2;
  logic [5:0]  mask2;
  logic [23:0] I2;
  logic [3:0]  out2;
  logic [2:0]  ch2;
  logic        v2, w2;

  mux_scan_n #(.WIDTH(4), .CHANNELS(8), .DWELL(3)) u0 (
    .clk(clk), .rst(rst0), .en(en0), .mode(mode0), .sel(sel0), .mask(mask0),
    .I(I0), .Out(out0), .ch(ch0), .valid(v0), .wrap(w0)
  );
  mux_scan_n #(.WIDTH(4), .CHANNELS(8), .DWELL(2)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel(sel1), .mask(mask1),
    .I(I1), .Out(out1), .ch(ch1), .valid(v1), .wrap(w1)
  );
  mux_scan_n #(.WIDTH(4), .CHANNELS(6), .DWELL(1)) u2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sel(sel2), .mask(mask2),
    .I(I2), .Out(out2), .ch(ch2), .valid(v2), .wrap(w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input int u, input exp_t e, input logic [3:0] o, input logic [2:0] c,
                     input logic v, input logic w);
    checks++;
    if (o !== e.o || c !== e.c || v !== e.v || w !== e.w) begin
      errors++;
      $display("FAIL u%0d step%0d: got out=%h ch=%0d valid=%b wrap=%b, expected out=%h ch=%0d valid=%b wrap=%b",
               u, e.id, o, c, v, w, e.o, e.c, e.v, e.w);
    end
  endtask

  // Monitor: every output sample after an edge is matched against the queue head.
  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) cmp(0, q0.pop_front(), out0, ch0, v0, w0);
    if (q1.size() > 0) cmp(1, q1.pop_front(), out1, ch1, v1, w1);
    if (q2.size() > 0) cmp(2, q2.pop_front(), out2, ch2, v2, w2);
  end

  // Inputs already set for this cycle; queue the sample expected after the next edge.
  task automatic ex(input int u, input logic [3:0] o, input logic [2:0] c,
                    input logic v, input logic w);
    exp_t e;
    e.o = o; e.c = c; e.v = v; e.w = w; e.id = step;
    step++;
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst0 = 1; en0 = 1; mode0 = 1; sel0 = 0; mask0 = 8'hFF; I0 = '1;
    rst1 = 1; en1 = 0; mode1 = 0; sel1 = 0; mask1 = 8'h00; I1 = 32'hFEDC_BA98;
    rst2 = 1; en2 = 0; mode2 = 0; sel2 = 0; mask2 = 6'h00; I2 = 24'h54_3210;
    @(negedge clk);

    // reset held with scan requested and all-ones data
    ex(0, 4'h0, 3'd0, 0, 0);
    ex(0, 4'h0, 3'd0, 0, 0);
    rst0 = 0; en0 = 0;
    ex(0, 4'h0, 3'd0, 0, 0);
    ex(0, 4'h0, 3'd0, 0, 0);

    // manual select, one-hot then inverted
    en0 = 1; mode0 = 0;
    for (int s = 0; s < 8; s++) begin
      sel0 = 3'(s); I0 = 32'h1 << (4 * s);
      ex(0, 4'h1, 3'(s), 1, 0);
    end
    for (int s = 0; s < 8; s++) begin
      sel0 = 3'(s); I0 = ~(32'hF << (4 * s));
      ex(0, 4'h0, 3'(s), 1, 0);
    end

    // full-mask scan: entry edge holds last manual Out/ch
    mode0 = 1; mask0 = 8'hFF; I0 = 32'h7654_3210;
    ex(0, 4'h0, 3'd7, 0, 0);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 3; j++)
        ex(0, 4'(k), 3'(k), 1, (k == 7 && j == 2));
    for (int j = 0; j < 3; j++) ex(0, 4'h0, 3'd0, 1, 0);
    for (int k = 1; k < 5; k++)
      for (int j = 0; j < 3; j++)
        ex(0, 4'(k), 3'(k), 1, 0);
    ex(0, 4'h5, 3'd5, 1, 0);

    // reset during channel 5, restart at lowest bit of new mask
    rst0 = 1;
    ex(0, 4'h0, 3'd0, 0, 0);
    rst0 = 0; mask0 = 8'h28;
    ex(0, 4'h0, 3'd0, 0, 0);
    for (int j = 0; j < 3; j++) ex(0, 4'h3, 3'd3, 1, 0);
    for (int j = 0; j < 3; j++) ex(0, 4'h5, 3'd5, 1, (j == 2));

    // scan -> manual, then idle holds
    mode0 = 0; sel0 = 3'd3;
    ex(0, 4'h3, 3'd3, 1, 0);
    en0 = 0;
    ex(0, 4'h3, 3'd3, 0, 0);

    // sparse mask with mid-dwell drop of channel 4, then empty mask
    rst1 = 0; en1 = 1; mode1 = 1; mask1 = 8'b1001_0010;
    ex(1, 4'h0, 3'd0, 0, 0);
    ex(1, 4'h9, 3'd1, 1, 0);
    ex(1, 4'h9, 3'd1, 1, 0);
    ex(1, 4'hC, 3'd4, 1, 0);
    ex(1, 4'hC, 3'd4, 1, 0);
    ex(1, 4'hF, 3'd7, 1, 0);
    ex(1, 4'hF, 3'd7, 1, 1);
    ex(1, 4'h9, 3'd1, 1, 0);
    ex(1, 4'h9, 3'd1, 1, 0);
    ex(1, 4'hC, 3'd4, 1, 0);
    mask1 = 8'b1000_0010;
    ex(1, 4'hC, 3'd4, 0, 0);
    ex(1, 4'hF, 3'd7, 1, 0);
    ex(1, 4'hF, 3'd7, 1, 1);
    ex(1, 4'h9, 3'd1, 1, 0);
    mask1 = 8'h00; I1 = 32'h0;
    ex(1, 4'h9, 3'd1, 0, 0);
    ex(1, 4'h9, 3'd1, 0, 0);

    // single-channel scan wraps every cycle; out-of-range manual select
    rst2 = 0; en2 = 1; mode2 = 1; mask2 = 6'b000100;
    ex(2, 4'h0, 3'd0, 0, 0);
    for (int j = 0; j < 4; j++) ex(2, 4'h2, 3'd2, 1, 1);
    mode2 = 0; sel2 = 3'd7;
    ex(2, 4'h0, 3'd7, 0, 0);
    sel2 = 3'd6;
    ex(2, 4'h0, 3'd6, 0, 0);
    sel2 = 3'd5;
    ex(2, 4'h5, 3'd5, 1, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples never compared, required 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
